// File: rtl/sign_extn_pipe_if.sv
// Handshake bundle for sign_extn_pipe: upstream beat, downstream result and buffer state.
// The master side feeds beats and accepts results; the slave side is the extension unit.
interface sign_extn_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    localparam int WS_W = $clog2(IN_W + 1);

    // A beat moves on any rising edge where valid and ready are both high.
    // Valid never waits on ready; in_ready is a registered signal.
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [WS_W-1:0]   in_width;
    logic              in_signed;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_neg;
    logic [1:0]        buf_state;

    modport master (
        output in_valid, in_data, in_width, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_neg, buf_state
    );

    modport slave (
        input  in_valid, in_data, in_width, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_neg, buf_state
    );
endinterface

// File: rtl/sign_extn_pipe.sv
// Pipelined sign/zero extension of a runtime-selected low field, with a 2-entry skid buffer.
// Optional accepted-beat extension counter is built when SIGN_EXTN_CNT_EN is defined.
module sign_extn_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    sign_extn_pipe_if.slave   bus,
    output logic [15:0]       ext_count
);
    localparam int WS_W = $clog2(IN_W + 1);

    if (IN_W < 2) begin : g_bad_in_w
        $fatal(1, "sign_extn_pipe: IN_W must be at least 2");
    end
    if (OUT_W < IN_W) begin : g_bad_out_w
        $fatal(1, "sign_extn_pipe: OUT_W must be >= IN_W");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    buf_state_t        state;
    buf_state_t        next_state;
    logic              in_ready_q;
    logic [OUT_W-1:0]  main_q;
    logic [OUT_W-1:0]  skid_q;

    logic              accept;
    logic              xfer;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    int                eff_w;
    logic              src_sign;
    logic              fill;
    logic [OUT_W-1:0]  ext_word;

    // Field widths of zero or beyond the word fall back to the full input word.
    always_comb begin : p_extend
        eff_w = IN_W;
        if (bus.in_width != '0 && bus.in_width <= WS_W'(IN_W)) begin
            eff_w = int'(bus.in_width);
        end
        src_sign = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (i == eff_w - 1) begin
                src_sign = bus.in_data[i];
            end
        end
        fill     = bus.in_signed & src_sign;
        ext_word = {OUT_W{fill}};
        for (int i = 0; i < IN_W; i++) begin
            if (i < eff_w) begin
                ext_word[i] = bus.in_data[i];
            end
        end
    end

    assign accept = bus.in_valid & in_ready_q;
    assign xfer   = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin : p_state_reg
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= next_state;
            in_ready_q <= (next_state != FULL);
        end
    end

    always_comb begin : p_next_state
        next_state = state;
        case (state)
            EMPTY: begin
                if (accept) next_state = ONE;
            end
            ONE: begin
                if (accept && !xfer)      next_state = FULL;
                else if (!accept && xfer) next_state = EMPTY;
            end
            FULL: begin
                if (xfer) next_state = ONE;
            end
            default: next_state = EMPTY;
        endcase
    end

    always_comb begin : p_outputs
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                load_main_in = accept;
            end
            ONE: begin
                load_main_in = accept & xfer;
                load_skid    = accept & ~xfer;
            end
            FULL: begin
                load_main_skid = xfer;
            end
            default: begin
                load_main_in = 1'b0;
            end
        endcase
    end

    // main_q only changes on a transfer or when empty, so a stalled result holds.
    always_ff @(posedge clk) begin : p_data_reg
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= ext_word;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= ext_word;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_data  = main_q;
    assign bus.out_neg   = main_q[OUT_W-1];
    assign bus.buf_state = state;

`ifdef SIGN_EXTN_CNT_EN
    logic [15:0] cnt_q;
    logic        cnt_hit;

    assign cnt_hit = accept & bus.in_signed & src_sign & (eff_w < OUT_W);

    always_ff @(posedge clk) begin : p_ext_count
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_hit) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign ext_count = cnt_q;
`else
    assign ext_count = '0;
`endif
endmodule

// File: tb/tb_sign_extn_pipe.sv
// Bench for sign_extn_pipe: table vectors, back-pressure, streaming and reset-in-FULL sequences.
// A negedge monitor keeps the expected-result queue and the extension-count model.
module tb_sign_extn_pipe;
    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int WS_W  = $clog2(IN_W + 1);

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ext_count;

    sign_extn_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    sign_extn_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ext_count (ext_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int out_cnt  = 0;
    int cyc      = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] e;
    logic [15:0]      exp_cnt = '0;
    logic             stall_prev = 1'b0;
    logic [OUT_W-1:0] stall_data = '0;

    typedef struct {
        logic [IN_W-1:0]  data;
        logic [WS_W-1:0]  width;
        logic             sgn;
        logic [OUT_W-1:0] exp_data;
        logic             exp_neg;
    } vec_t;

    vec_t vecs[10];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int eff_width(input logic [WS_W-1:0] w);
        return (w == 0 || int'(w) > IN_W) ? IN_W : int'(w);
    endfunction

    function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] d,
                                                 input logic [WS_W-1:0] w, input logic s);
        int          ew;
        logic [63:0] mask;
        logic [63:0] r;
        ew   = eff_width(w);
        mask = (64'd1 << ew) - 64'd1;
        r    = 64'(d) & mask;
        if (s && ((r >> (ew - 1)) & 64'd1) != 64'd0) r = r | ~mask;
        return r[OUT_W-1:0];
    endfunction

    function automatic logic ref_hit(input logic [IN_W-1:0] d,
                                     input logic [WS_W-1:0] w, input logic s);
        int ew;
        ew = eff_width(w);
        return s && (((64'(d) >> (ew - 1)) & 64'd1) != 64'd0) && (ew < OUT_W);
    endfunction

    // Scoreboard: a transfer or accept seen at negedge completes on the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt    = '0;
            stall_prev = 1'b0;
        end else begin
            check("ext_count", 64'(ext_count), 64'(exp_cnt));
            if (stall_prev && bus.out_valid)
                check("stall_hold", 64'(bus.out_data), 64'(stall_data));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got 0x%0h expected no beat", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(bus.out_data), 64'(e));
                    check("out_neg", 64'(bus.out_neg), 64'(e[OUT_W-1]));
                end
                out_cnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_ext(bus.in_data, bus.in_width, bus.in_signed));
`ifdef SIGN_EXTN_CNT_EN
                if (ref_hit(bus.in_data, bus.in_width, bus.in_signed)) exp_cnt = exp_cnt + 16'd1;
`endif
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [IN_W-1:0] d, input logic [WS_W-1:0] w, input logic s);
        logic rdy;
        int   n;
        bus.in_data   = d;
        bus.in_width  = w;
        bus.in_signed = s;
        bus.in_valid  = 1'b1;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            rdy = bus.in_ready;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", n);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    int o0;
    int t0;

    initial begin
        vecs[0] = '{16'h8001, 5'd16, 1'b1, 32'hFFFF8001, 1'b1};
        vecs[1] = '{16'hF800, 5'd12, 1'b1, 32'hFFFFF800, 1'b1};
        vecs[2] = '{16'hF800, 5'd12, 1'b0, 32'h00000800, 1'b0};
        vecs[3] = '{16'h07FF, 5'd12, 1'b1, 32'h000007FF, 1'b0};
        vecs[4] = '{16'h7FFF, 5'd0,  1'b1, 32'h00007FFF, 1'b0};
        vecs[5] = '{16'h7FFF, 5'd17, 1'b1, 32'h00007FFF, 1'b0};
        vecs[6] = '{16'h0001, 5'd1,  1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[7] = '{16'hFFFE, 5'd1,  1'b1, 32'h00000000, 1'b0};
        vecs[8] = '{16'hABCD, 5'd8,  1'b0, 32'h000000CD, 1'b0};
        vecs[9] = '{16'h1234, 5'd31, 1'b1, 32'h00001234, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_width  = '0;
        bus.in_signed = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_neg", 64'(bus.out_neg), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_ext_count", 64'(ext_count), 64'd0);
        check("rst_state", 64'(bus.buf_state), 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready_low", 64'(bus.in_ready), 64'd0);
        tick();
        @(negedge clk);
        check("rel_in_ready_high", 64'(bus.in_ready), 64'd1);
        tick();

        // Table vectors, one beat at a time with 1-cycle latency
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_beat(vecs[i].data, vecs[i].width, vecs[i].sgn);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("vec%0d_data", i), 64'(bus.out_data), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_neg", i), 64'(bus.out_neg), 64'(vecs[i].exp_neg));
            tick();
        end
        drain("vec_drain");

        // Back-pressure: A and B accepted, C held until the stall is released
        o0 = out_cnt;
        bus.out_ready = 1'b0;
        bus.in_data   = 16'h0001;
        bus.in_width  = 5'd16;
        bus.in_signed = 1'b1;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        check("bp_ready_a", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_data = 16'h0002;
        @(negedge clk);
        check("bp_ready_b", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_data = 16'h0003;
        @(negedge clk);
        check("bp_ready_c", 64'(bus.in_ready), 64'd0);
        check("bp_state_full", 64'(bus.buf_state), 64'd2);
        check("bp_head_a", 64'(bus.out_data), 64'h1);
        repeat (2) tick();
        @(negedge clk);
        check("bp_still_held", 64'(bus.in_ready), 64'd0);
        check("bp_head_a_hold", 64'(bus.out_data), 64'h1);
        tick();
        bus.out_ready = 1'b1;
        drive_beat(16'h0003, 5'd16, 1'b1);
        drain("bp_drain");
        check("bp_count", 64'(out_cnt - o0), 64'd3);

        // Streaming at full throughput
        bus.out_ready = 1'b1;
        t0 = cyc;
        o0 = out_cnt;
        for (int i = 0; i < 100; i++) begin
            drive_beat(IN_W'($urandom()), WS_W'($urandom_range(0, 17)), 1'($urandom_range(0, 1)));
        end
        tick();
        check("stream_cycles", 64'(cyc - t0), 64'd101);
        check("stream_outputs", 64'(out_cnt - o0), 64'd100);
        check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset while FULL discards both buffered beats
        bus.out_ready = 1'b0;
        bus.in_data   = 16'h8000;
        bus.in_width  = 5'd16;
        bus.in_signed = 1'b1;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_data = 16'h0F0F;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_state", 64'(bus.buf_state), 64'd2);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("frst_out_valid", 64'(bus.out_valid), 64'd0);
        check("frst_out_data", 64'(bus.out_data), 64'd0);
        check("frst_out_neg", 64'(bus.out_neg), 64'd0);
        check("frst_ext_count", 64'(ext_count), 64'd0);
        check("frst_state", 64'(bus.buf_state), 64'd0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("no_stale%0d", i), 64'(bus.out_valid), 64'd0);
            tick();
        end
        drive_beat(16'h00FF, 5'd8, 1'b1);
        @(negedge clk);
        check("post_rst_data", 64'(bus.out_data), 64'hFFFFFFFF);
        tick();
        drain("post_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
